image_mem_arb: RTL

- Single-port access scheduler placed in front of image_mem.
- Shares the one memory port between two requesters: a write stream from the image loader and a read-request stream from the convolution address generator.
- Enforces at most one access per cycle, with write priority bounded by a fairness limit.
- Tags read returns with a valid strobe aligned to image_mem's fixed read latency, and flow-controls reads against downstream buffer credits.

---
 rtl/image_mem_arb_if.sv | 51 +++++
 rtl/image_mem_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/image_mem_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : image_mem_arb_if                                             |
// | Description : Bus bundle between the image loader / convolution address    |
// |               generator, the image_mem_arb scheduler and image_mem.        |
// |               slave  : scheduler side (takes requests, drives image_mem).  |
// |               master : environment side (requesters, image_mem, credits).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface image_mem_arb_if #(
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int CREDIT_NB  = 4
);
  // write stream from the image loader
  logic                              wr_val;
  logic                              wr_rdy;
  logic [MEM_AWIDTH-1:0]             wr_addr;
  logic [IMG_WIDTH*DEPTH_NB-1:0]     wr_data;
  // read-request stream from the convolution address generator
  logic                              rd_val;
  logic                              rd_rdy;
  logic [MEM_AWIDTH-1:0]             rd_addr;
  // image_mem port
  logic                              mem_wr_val;
  logic [MEM_AWIDTH-1:0]             mem_wr_addr;
  logic [IMG_WIDTH*DEPTH_NB-1:0]     mem_wr_data;
  logic                              mem_rd_val;
  logic [MEM_AWIDTH-1:0]             mem_rd_addr;
  logic [GROUP_NB*IMG_WIDTH-1:0]     mem_rd_data;
  // read response and downstream credit return
  logic                              rsp_val;
  logic [GROUP_NB*IMG_WIDTH-1:0]     rsp_data;
  logic                              rsp_credit;
  logic [$clog2(CREDIT_NB):0]        outstanding;

  modport slave (
    input  wr_val, wr_addr, wr_data, rd_val, rd_addr, mem_rd_data, rsp_credit,
    output wr_rdy, rd_rdy, mem_wr_val, mem_wr_addr, mem_wr_data,
           mem_rd_val, mem_rd_addr, rsp_val, rsp_data, outstanding
  );

  modport master (
    output wr_val, wr_addr, wr_data, rd_val, rd_addr, mem_rd_data, rsp_credit,
    input  wr_rdy, rd_rdy, mem_wr_val, mem_wr_addr, mem_wr_data,
           mem_rd_val, mem_rd_addr, rsp_val, rsp_data, outstanding
  );
endinterface
`default_nettype wire

// File: rtl/image_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : image_mem_arb                                                |
// | Description : Single-port access scheduler in front of image_mem. Writes   |
// |               win by default; after WR_RUN_MAX write grants in a row while |
// |               a read waits, one read is forced through. Reads are limited  |
// |               by downstream credits; rsp_val is the read grant delayed by  |
// |               image_mem's fixed RD_LAT latency.                            |
// | Ports       : clk, rst (sync, active high)                                 |
// |               bus.slave : wr_* / rd_* requests, mem_* to image_mem,        |
// |                           rsp_val/rsp_data, rsp_credit, outstanding        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module image_mem_arb #(
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int RD_LAT     = 3,
  parameter int WR_RUN_MAX = 8,
  parameter int CREDIT_NB  = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  image_mem_arb_if.slave   bus
);

  localparam int CW = $clog2(CREDIT_NB) + 1;
  localparam int RW = $clog2(WR_RUN_MAX + 1);
  localparam logic [CW-1:0] C_CREDITS  = CW'(CREDIT_NB);
  localparam logic [RW-1:0] C_RUN_LAST = RW'(WR_RUN_MAX - 1);

  typedef enum logic [0:0] {
    WR_PRI   = 1'b0,
    RD_FORCE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     run_cnt_q, run_cnt_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [RD_LAT-1:0] vld_q;

  logic wr_gnt, rd_gnt;

  // Grants: reset forces the write-ready/read-blocked view regardless of state.
  assign bus.wr_rdy = rst | (state_q == WR_PRI);
  assign bus.rd_rdy = ~rst & (credit_q != '0) & (~bus.wr_val | (state_q == RD_FORCE));
  assign wr_gnt     = bus.wr_val & bus.wr_rdy;
  assign rd_gnt     = bus.rd_val & bus.rd_rdy;

  assign bus.mem_wr_val  = wr_gnt;
  assign bus.mem_wr_addr = bus.wr_addr;
  assign bus.mem_wr_data = bus.wr_data;
  assign bus.mem_rd_val  = rd_gnt;
  assign bus.mem_rd_addr = bus.rd_addr;

  assign bus.rsp_val     = vld_q[RD_LAT-1];
  assign bus.rsp_data    = bus.mem_rd_data;
  assign bus.outstanding = C_CREDITS - credit_q;

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      WR_PRI: begin
        // Count writes that overtake a waiting read; the last one hands
        // the port to the read.
        if (wr_gnt && bus.rd_val) begin
          if (run_cnt_q == C_RUN_LAST) begin
            state_d   = RD_FORCE;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else if (wr_gnt || rd_gnt) begin
          run_cnt_d = '0;
        end
      end
      RD_FORCE: begin
        // With no credit the read cannot go, so writes stay blocked here.
        if (rd_gnt || !bus.rd_val) begin
          state_d = WR_PRI;
        end
        run_cnt_d = '0;
      end
      default: begin
        state_d   = WR_PRI;
        run_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    case ({rd_gnt, bus.rsp_credit})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   if (credit_q != C_CREDITS) credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WR_PRI;
      run_cnt_q <= '0;
      credit_q  <= C_CREDITS;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      credit_q  <= credit_d;
    end
  end

  // Response strobe tracks image_mem's fixed latency; clearing it on reset
  // drops any reads still in flight.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= rd_gnt;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= {vld_q[RD_LAT-2:0], rd_gnt};
      end
    end
  endgenerate

  // A credit returned while every slot is already free is a downstream bug.
  a_credit_overflow: assert property (
    @(posedge clk) disable iff (rst) !(bus.rsp_credit && (credit_q == C_CREDITS))
  );

endmodule
`default_nettype wire
